// File: rtl/alias_readback_checker_if.sv
// Bus bundle between an alias-group driver/monitor and alias_readback_checker.
// ALIAS_CHK_FIRST_BAD_EN adds the first-bad-sample capture signals.
interface alias_readback_checker_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       err_count;
`ifdef ALIAS_CHK_FIRST_BAD_EN
    logic [9:0]       first_bad_idx;
    logic [WIDTH-1:0] first_bad_val;
`endif

    modport master (
        output start, a, b, c,
`ifdef ALIAS_CHK_FIRST_BAD_EN
        input  first_bad_idx, first_bad_val,
`endif
        input  busy, done, pass, err_count
    );

    modport slave (
        input  start, a, b, c,
`ifdef ALIAS_CHK_FIRST_BAD_EN
        output first_bad_idx, first_bad_val,
`endif
        output busy, done, pass, err_count
    );
endinterface

// File: rtl/alias_readback_checker.sv
// Self-checking reader of a driven alias group: a, b and c must all equal EXPECT
// for CHECK_CYCLES samples. ALIAS_CHK_FIRST_BAD_EN adds first-bad-sample capture.
module alias_readback_checker #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] EXPECT        = WIDTH'(32'hdeadbeef),
    parameter int               SETTLE_CYCLES = 2,
    parameter int               CHECK_CYCLES  = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    alias_readback_checker_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_CYCLES - 1);

    state_t      state_r;
    state_t      state_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic        start_run_s;
    logic        sample_s;
    logic        bad_s;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic [7:0]  err_r;

    assign sample_s = (state_r == ST_CHECK);
    assign bad_s    = (bus.a != EXPECT) || (bus.b != EXPECT) || (bus.c != EXPECT);

    // Next-state and phase counter; cnt_r doubles as the sample index k in CHECK.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        start_run_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    start_run_s = 1'b1;
                    cnt_s       = 16'd0;
                    state_s     = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    cnt_s   = 16'd0;
                    state_s = ST_CHECK;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_CHECK: begin
                if (cnt_r == CHECK_LAST) begin
                    cnt_s   = 16'd0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_DONE: begin
                cnt_s   = 16'd0;
                state_s = ST_IDLE;
            end
            default: begin
                cnt_s   = 16'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Outputs lag the state by one edge, so busy falls exactly as done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= 8'd0;
        end else begin
            busy_r <= (state_r == ST_SETTLE) || (state_r == ST_CHECK);
            done_r <= (state_r == ST_DONE);
            if (start_run_s) begin
                err_r  <= 8'd0;
                pass_r <= 1'b0;
            end else if (state_r == ST_DONE) begin
                pass_r <= (err_r == 8'd0);
            end else if (sample_s && bad_s && (err_r != 8'hff)) begin
                err_r <= err_r + 8'd1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;

`ifdef ALIAS_CHK_FIRST_BAD_EN
    logic [9:0]       first_idx_r;
    logic [WIDTH-1:0] first_val_r;

    // 10'h3ff is never a legal index, so it also serves as the "nothing captured" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_idx_r <= 10'h3ff;
            first_val_r <= '0;
        end else if (start_run_s) begin
            first_idx_r <= 10'h3ff;
            first_val_r <= '0;
        end else if (sample_s && bad_s && (first_idx_r == 10'h3ff)) begin
            first_idx_r <= cnt_r[9:0];
            first_val_r <= bus.a;
        end else begin
            first_idx_r <= first_idx_r;
            first_val_r <= first_val_r;
        end
    end

    assign bus.first_bad_idx = first_idx_r;
    assign bus.first_bad_val = first_val_r;
`endif
endmodule

// File: tb/tb_alias_readback_checker.sv
// Directed bench for alias_readback_checker: default instance (S=2, N=8) and a
// long-run instance (S=0, N=300). First-bad checks build with ALIAS_CHK_FIRST_BAD_EN.
module tb_alias_readback_checker;
    localparam logic [31:0] DB = 32'hdeadbeef;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   at;
    int   pulses;

    alias_readback_checker_if #(.WIDTH(32)) if0 ();
    alias_readback_checker_if #(.WIDTH(32)) if1 ();

    alias_readback_checker #(.WIDTH(32), .EXPECT(DB), .SETTLE_CYCLES(2), .CHECK_CYCLES(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    alias_readback_checker #(.WIDTH(32), .EXPECT(DB), .SETTLE_CYCLES(0), .CHECK_CYCLES(300)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start0();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
    endtask

    // Returns the edge count (after the start edge) at which done was seen, or -1.
    task automatic wait_done0(output int edge_n);
        edge_n = -1;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (if0.done === 1'b1) begin
                edge_n = i;
                break;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        if0.start = 1'b0; if0.a = DB; if0.b = DB; if0.c = DB;
        if1.start = 1'b0; if1.a = DB; if1.b = DB; if1.c = DB;
        #2;
        chk("rst_busy", {31'd0, if0.busy}, 32'd0);
        chk("rst_done", {31'd0, if0.done}, 32'd0);
        chk("rst_pass", {31'd0, if0.pass}, 32'd0);
        chk("rst_err",  {24'd0, if0.err_count}, 32'd0);
`ifdef ALIAS_CHK_FIRST_BAD_EN
        chk("rst_fb_idx", {22'd0, if0.first_bad_idx}, 32'h3ff);
        chk("rst_fb_val", if0.first_bad_val, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: clean run, exact busy/done timing
        start0();
        chk("t1_busy_e0", {31'd0, if0.busy}, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("t1_busy_e%0d", i), {31'd0, if0.busy}, {31'd0, (i <= 10)});
            chk($sformatf("t1_done_e%0d", i), {31'd0, if0.done}, {31'd0, (i == 11)});
            if (i == 11) begin
                chk("t1_pass", {31'd0, if0.pass}, 32'd1);
                chk("t1_err",  {24'd0, if0.err_count}, 32'd0);
            end
        end
`ifdef ALIAS_CHK_FIRST_BAD_EN
        chk("t1_fb_idx", {22'd0, if0.first_bad_idx}, 32'h3ff);
        chk("t1_fb_val", if0.first_bad_val, 32'd0);
`endif

        // 2: b=0 at samples k=2,3,4 (edges 5,6,7)
        start0();
        chk("t2_pass_cleared", {31'd0, if0.pass}, 32'd0);
        for (int i = 1; i <= 11; i++) begin
            if0.b = (i >= 5 && i <= 7) ? 32'd0 : DB;
            tick();
        end
        if0.b = DB;
        chk("t2_done", {31'd0, if0.done}, 32'd1);
        chk("t2_pass", {31'd0, if0.pass}, 32'd0);
        chk("t2_err",  {24'd0, if0.err_count}, 32'd3);
`ifdef ALIAS_CHK_FIRST_BAD_EN
        chk("t2_fb_idx", {22'd0, if0.first_bad_idx}, 32'd2);
        chk("t2_fb_val", if0.first_bad_val, DB);
`endif

        // 3: start re-pulsed mid-run is ignored
        tick();
        start0();
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 14; i++) begin
            if0.start = (i == 3 || i == 9);
            tick();
            if (if0.done === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        if0.start = 1'b0;
        chk("t3_pulses", pulses, 32'd1);
        chk("t3_done_edge", at, 32'd11);
        start0();
        wait_done0(at);
        chk("t3_rerun_edge", at, 32'd11);
        chk("t3_rerun_pass", {31'd0, if0.pass}, 32'd1);

        // 4: async reset during CHECK, then clean restart
        tick();
        start0();
        if0.c = 32'd0;
        for (int i = 1; i <= 6; i++) tick();
        chk("t4_err_pre", {24'd0, if0.err_count}, 32'd4);
        chk("t4_busy_pre", {31'd0, if0.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_busy", {31'd0, if0.busy}, 32'd0);
        chk("t4_done", {31'd0, if0.done}, 32'd0);
        chk("t4_pass", {31'd0, if0.pass}, 32'd0);
        chk("t4_err",  {24'd0, if0.err_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        if0.c = DB;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if0.done === 1'b1) pulses++;
        end
        chk("t4_no_done", pulses, 32'd0);
        start0();
        wait_done0(at);
        chk("t4_restart_edge", at, 32'd11);
        chk("t4_restart_pass", {31'd0, if0.pass}, 32'd1);
        chk("t4_restart_err",  {24'd0, if0.err_count}, 32'd0);

        // 5: N=300, S=0, c=0 throughout -> saturates at 255
        tick();
        if1.c = 32'd0;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("t5_busy_e0", {31'd0, if1.busy}, 32'd0);
        at = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (if1.done === 1'b1) begin
                at = i;
                break;
            end
        end
        chk("t5_done_edge", at, 32'd301);
        chk("t5_err", {24'd0, if1.err_count}, 32'd255);
        chk("t5_pass", {31'd0, if1.pass}, 32'd0);
`ifdef ALIAS_CHK_FIRST_BAD_EN
        chk("t5_fb_idx", {22'd0, if1.first_bad_idx}, 32'd0);
        chk("t5_fb_val", if1.first_bad_val, DB);
`endif
        if1.c = DB;

`ifdef ALIAS_CHK_FIRST_BAD_EN
        // 6: all nets zero at k=4 only (edge 7)
        tick();
        start0();
        for (int i = 1; i <= 11; i++) begin
            if0.a = (i == 7) ? 32'd0 : DB;
            if0.b = (i == 7) ? 32'd0 : DB;
            if0.c = (i == 7) ? 32'd0 : DB;
            tick();
        end
        if0.a = DB; if0.b = DB; if0.c = DB;
        chk("t6_done", {31'd0, if0.done}, 32'd1);
        chk("t6_fb_idx", {22'd0, if0.first_bad_idx}, 32'd4);
        chk("t6_fb_val", if0.first_bad_val, 32'd0);
        chk("t6_err", {24'd0, if0.err_count}, 32'd1);
        start0();
        wait_done0(at);
        chk("t6_clean_idx", {22'd0, if0.first_bad_idx}, 32'h3ff);
        chk("t6_clean_val", if0.first_bad_val, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
